// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: operation codes and FSM state encoding.
package stack_pkg;
    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/stack_depth_ctr.sv
// Saturating up/down occupancy counter with full/empty flags for the stack controller.
module stack_depth_ctr #(
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          async_reset,
    input  logic          inc,
    input  logic          dec,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] count_reg;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            count_reg <= '0;
        end else if (inc && !dec && !full) begin
            count_reg <= count_reg + 1'b1;
        end else if (dec && !inc && !empty) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign depth = count_reg;
    assign full  = (count_reg == DW'(DEPTH));
    assign empty = (count_reg == '0);
endmodule

// File: rtl/stack_ctrl.sv
// Stack controller driving a shift-cell array; STACK_ERR_STICKY_EN makes err hold until reset or an accepted NOP.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic                       op_valid,
    input  logic [1:0]                 op_code,
    input  logic [WIDTH-1:0]           op_data,
    output logic                       op_ready,
    input  logic [WIDTH-1:0]           tos_data,
    output logic                       push,
    output logic                       pop,
    output logic                       overwrite,
    output logic                       data_write,
    output logic                       data_read,
    output logic [WIDTH-1:0]           cell_data,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);
    state_t           state_reg;
    logic [1:0]       op_code_reg;
    logic             push_reg, pop_reg, overwrite_reg;
    logic             rd_valid_reg, err_reg;
    logic [WIDTH-1:0] cell_data_reg, rd_data_reg;

    stack_depth_ctr #(.DEPTH(DEPTH), .DW($clog2(DEPTH+1))) u_depth (
        .clk         (clk),
        .async_reset (async_reset),
        .inc         (push_reg),
        .dec         (pop_reg),
        .depth       (depth),
        .full        (full),
        .empty       (empty)
    );

    // Controls are decided at the accept edge so they are high for exactly the EXEC cycle.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_reg     <= IDLE;
            op_code_reg   <= OP_NOP;
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            overwrite_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            err_reg       <= 1'b0;
            cell_data_reg <= '0;
            rd_data_reg   <= '0;
        end else begin
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            overwrite_reg <= 1'b0;
`ifndef STACK_ERR_STICKY_EN
            err_reg       <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        op_code_reg <= op_code;
                        if (op_code == OP_NOP) begin
`ifdef STACK_ERR_STICKY_EN
                            err_reg <= 1'b0;
`endif
                        end else begin
                            state_reg <= EXEC;
                            case (op_code)
                                OP_PUSH: begin
                                    if (!full) begin
                                        push_reg      <= 1'b1;
                                        cell_data_reg <= op_data;
                                    end else begin
                                        err_reg <= 1'b1;
                                    end
                                end
                                OP_POP: begin
                                    if (!empty) pop_reg <= 1'b1;
                                    else        err_reg <= 1'b1;
                                end
                                default: begin
                                    if (!empty) begin
                                        overwrite_reg <= 1'b1;
                                        cell_data_reg <= op_data;
                                    end else begin
                                        err_reg <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                EXEC: begin
                    if (op_code_reg == OP_POP) begin
                        rd_data_reg  <= pop_reg ? tos_data : '0;
                        rd_valid_reg <= 1'b1;
                        state_reg    <= RESP;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RESP: begin
                    rd_valid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign op_ready   = (state_reg == IDLE);
    assign push       = push_reg;
    assign pop        = pop_reg;
    assign overwrite  = overwrite_reg;
    assign data_write = push_reg;
    assign data_read  = pop_reg;
    assign cell_data  = cell_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_data_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: directed operations queue expected events, a negedge monitor checks them.
module tb_stack_ctrl;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             async_reset = 1'b1;
    logic             op_valid = 1'b0;
    logic [1:0]       op_code = 2'b00;
    logic [WIDTH-1:0] op_data = '0;
    logic [WIDTH-1:0] tos_data = '0;
    logic             op_ready, push, pop, overwrite, data_write, data_read;
    logic [WIDTH-1:0] cell_data, rd_data;
    logic             rd_valid, full, empty, err;
    logic [DW-1:0]    depth;

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .async_reset(async_reset), .op_valid(op_valid), .op_code(op_code),
        .op_data(op_data), .op_ready(op_ready), .tos_data(tos_data), .push(push),
        .pop(pop), .overwrite(overwrite), .data_write(data_write), .data_read(data_read),
        .cell_data(cell_data), .rd_valid(rd_valid), .rd_data(rd_data), .depth(depth),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PUSH, EV_POP, EV_OVW, EV_RD, EV_ERR} ev_t;
    typedef struct {
        ev_t              kind;
        logic [WIDTH-1:0] data;
        logic [DW-1:0]    dep;
    } ev_s;

    ev_s  expq[$];
    int   total = 0;
    int   bad = 0;
    logic err_prev = 1'b0;
`ifdef STACK_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_t k, input logic [WIDTH-1:0] d, input logic [DW-1:0] dp);
        ev_s e;
        e.kind = k; e.data = d; e.dep = dp;
        expq.push_back(e);
    endtask

    task automatic seen(input ev_t k, input logic [WIDTH-1:0] d, input logic [DW-1:0] dp);
        ev_s e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d data=0x%0h required=none t=%0t", k, d, $time);
        end else begin
            e = expq.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            if (k == EV_PUSH || k == EV_OVW || k == EV_RD) chk("event_data", 32'(d), 32'(e.data));
            if (k == EV_RD) chk("rd_depth", 32'(dp), 32'(e.dep));
            $display("event kind=%0d data=0x%0h depth=%0d", k, d, dp);
        end
    endtask

    // Monitor: one scoreboard pop per DUT event, in fixed per-cycle order.
    always @(negedge clk) begin
        if (async_reset) begin
            err_prev <= 1'b0;
        end else begin
            if (push || pop || overwrite) begin
                chk("one_hot_ctrl", 32'(int'(push) + int'(pop) + int'(overwrite)), 32'd1);
                chk("data_write_eq_push", 32'(data_write), 32'(push));
                chk("data_read_eq_pop", 32'(data_read), 32'(pop));
            end
            if (push)      seen(EV_PUSH, cell_data, depth);
            if (pop)       seen(EV_POP, '0, depth);
            if (overwrite) seen(EV_OVW, cell_data, depth);
            if (rd_valid)  seen(EV_RD, rd_data, depth);
            if (err && !err_prev) seen(EV_ERR, '0, depth);
            err_prev <= err;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [1:0] code, input logic [WIDTH-1:0] d);
        wait_ready();
        op_valid = 1'b1; op_code = code; op_data = d;
        @(posedge clk);
        #1 op_valid = 1'b0;
        wait_ready();
        @(negedge clk);
        @(negedge clk);
        $display("op code=%0d data=0x%0h depth=%0d err=%0b", code, d, depth, err);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ctrl", 32'({push, pop, overwrite, data_write, data_read, rd_valid}), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_cell_data", 32'(cell_data), 32'd0);
        async_reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(op_ready), 32'd1);

        expect_ev(EV_PUSH, 16'h1111, 0); do_op(2'b01, 16'h1111);
        expect_ev(EV_PUSH, 16'h2222, 0); do_op(2'b01, 16'h2222);
        expect_ev(EV_PUSH, 16'h3333, 0); do_op(2'b01, 16'h3333);
        chk("depth_after_3_push", 32'(depth), 32'd3);
        chk("cell_data_hold", 32'(cell_data), 32'h3333);

        tos_data = 16'h3333;
        expect_ev(EV_POP, 0, 0); expect_ev(EV_RD, 16'h3333, 2); do_op(2'b10, 16'h0);
        chk("depth_after_pop", 32'(depth), 32'd2);
        chk("rd_data_hold", 32'(rd_data), 32'h3333);

        expect_ev(EV_OVW, 16'hA5A5, 0); do_op(2'b11, 16'hA5A5);
        chk("depth_after_replace", 32'(depth), 32'd2);
        chk("cell_data_replace", 32'(cell_data), 32'hA5A5);

        for (int i = 0; i < 6; i++) begin
            expect_ev(EV_PUSH, 16'(16'h4000 + i), 0);
            do_op(2'b01, 16'(16'h4000 + i));
        end
        chk("depth_full", 32'(depth), 32'd8);
        chk("full_flag", 32'(full), 32'd1);

        expect_ev(EV_ERR, 0, 0); do_op(2'b01, 16'hBEEF);
        chk("depth_stays_full", 32'(depth), 32'd8);
        chk("full_after_overflow", 32'(full), 32'd1);
        chk("cell_data_no_overwrite", 32'(cell_data), 32'h4005);
        chk("err_after_overflow", 32'(err), 32'(STICKY));
        do_op(2'b00, 16'h0);
        chk("err_after_nop", 32'(err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            tos_data = 16'(16'h7000 + i);
            expect_ev(EV_POP, 0, 0);
            expect_ev(EV_RD, 16'(16'h7000 + i), DW'(7 - i));
            do_op(2'b10, 16'h0);
        end
        chk("empty_flag", 32'(empty), 32'd1);

        tos_data = 16'hDEAD;
        expect_ev(EV_ERR, 0, 0); expect_ev(EV_RD, 16'h0, 0); do_op(2'b10, 16'h0);
        chk("depth_no_wrap", 32'(depth), 32'd0);
        chk("rd_data_zero", 32'(rd_data), 32'd0);
        chk("err_after_underflow", 32'(err), 32'(STICKY));
        do_op(2'b00, 16'h0);
        chk("err_cleared", 32'(err), 32'd0);

        expect_ev(EV_ERR, 0, 0); do_op(2'b11, 16'h5A5A);
        chk("replace_empty_depth", 32'(depth), 32'd0);
        do_op(2'b00, 16'h0);

        expect_ev(EV_PUSH, 16'h0101, 0); do_op(2'b01, 16'h0101);
        expect_ev(EV_PUSH, 16'h0202, 0); do_op(2'b01, 16'h0202);
        wait_ready();
        op_valid = 1'b1; op_code = 2'b11; op_data = 16'hCCCC;
        @(posedge clk);
        #1 op_valid = 1'b0;
        async_reset = 1'b1;
        repeat (2) @(negedge clk);
        async_reset = 1'b0;
        repeat (4) @(negedge clk);
        $display("op abort-by-reset depth=%0d", depth);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_cell_data", 32'(cell_data), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);

        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
